// File: rtl/obi_resp_emul.sv
// OBI response emulator: grants requests into an in-order pending FIFO and
// answers each one RESP_LATENCY cycles after grant with rdata = ~addr.
// Ports: clk_i/rst_i (async active-high); req_i, addr_i, stall_i from core/bench;
// gnt_o, rvalid_o, rdata_o, outstanding_o (pending count), err_o (sticky).
// Optional: define OBI_EMUL_PROTOCOL_CHECK_EN to enable the protocol checker
// driving err_o; without it err_o is tied to 0.
module obi_resp_emul #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned RESP_LATENCY    = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_i,
  input  logic [ADDR_WIDTH-1:0]                  addr_i,
  input  logic                                   stall_i,
  output logic                                   gnt_o,
  output logic                                   rvalid_o,
  output logic [DATA_WIDTH-1:0]                  rdata_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ?
                               $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned AW = 4;

  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [AW-1:0] AGE_MAX  = AW'(RESP_LATENCY);

  logic [ADDR_WIDTH-1:0] addr_q [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] addr_d [MAX_OUTSTANDING];
  logic [AW-1:0]         age_q  [MAX_OUTSTANDING];
  logic [AW-1:0]         age_d  [MAX_OUTSTANDING];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_ext;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_FULL);
  assign head_addr = addr_q[rd_ptr_q];
  assign head_ext  = DATA_WIDTH'(head_addr);

  // Head answers once it has aged RESP_LATENCY edges; answering retires it.
  assign pop  = ~empty & (age_q[rd_ptr_q] == AGE_MAX);

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign gnt  = req_i & ~stall_i & ~rst_i & (~full | pop);
  assign push = gnt;

  always_comb begin
    addr_d   = addr_q;
    age_d    = age_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;

    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + AW'(1);
      end
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // Age is zero in the grant cycle; the stored value is what it reads
    // one edge later, hence 1.
    if (push) begin
      addr_d[wr_ptr_q] = addr_i;
      age_d[wr_ptr_q]  = AW'(1);
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        addr_q[i] <= '0;
        age_q[i]  <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      age_q    <= age_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt_o         = gnt;
  assign rvalid_o      = pop;
  assign rdata_o       = pop ? ~head_ext : '0;
  assign outstanding_o = cnt_q;

`ifdef OBI_EMUL_PROTOCOL_CHECK_EN
  // A request left ungranted must hold both req_i and addr_i until granted.
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  err_q, err_d;

  always_comb begin
    pend_d  = req_i & ~gnt;
    paddr_d = addr_i;
    err_d   = err_q;
    if (pend_q & (~req_i | (addr_i != paddr_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= 1'b0;
      paddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_resp_emul.sv
// Bench for obi_resp_emul: three instances (2/1, 2/3, 1/1 outstanding/latency)
// checked each cycle against a grant-time queue model.
module tb_obi_resp_emul;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [3];
  logic        stall  [3];
  logic [31:0] addr   [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [31:0] rdata  [3];
  logic [1:0]  oc0, oc1;
  logic [0:0]  oc2;

  logic [31:0] qa [3][$];
  int          qt [3][$];
  bit          pend   [3];
  logic [31:0] paddr  [3];
  bit          sticky [3];
  bit          lastg  [3];
  int          cyc;
  int          n_vec;
  int          n_err;
  int          rv_cnt2;

  always #5 clk = ~clk;

  obi_resp_emul #(.MAX_OUTSTANDING(2), .RESP_LATENCY(1)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .addr_i(addr[0]),
    .stall_i(stall[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .outstanding_o(oc0), .err_o(err[0]));

  obi_resp_emul #(.MAX_OUTSTANDING(2), .RESP_LATENCY(3)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .addr_i(addr[1]),
    .stall_i(stall[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .outstanding_o(oc1), .err_o(err[1]));

  obi_resp_emul #(.MAX_OUTSTANDING(1), .RESP_LATENCY(1)) u2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .addr_i(addr[2]),
    .stall_i(stall[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .outstanding_o(oc2), .err_o(err[2]));

  function automatic int maxo(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic int lat(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge.
  task automatic tick();
    bit g  [3];
    bit rv [3];
    bit vi [3];
    logic [31:0] oc;
    logic [31:0] ed;
    bit          ee;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rv[i] = !rst && qa[i].size() > 0 && (cyc - qt[i][0]) >= lat(i);
      g[i]  = !rst && req[i] && !stall[i] &&
              (qa[i].size() < maxo(i) || rv[i]);
      vi[i] = !rst && pend[i] && (!req[i] || addr[i] != paddr[i]);
      ed    = rv[i] ? ~qa[i][0] : 32'h0;
      oc    = (i == 0) ? 32'(oc0) : (i == 1) ? 32'(oc1) : 32'(oc2);
`ifdef OBI_EMUL_PROTOCOL_CHECK_EN
      ee    = !rst && sticky[i];
`else
      ee    = 1'b0;
`endif
      chk($sformatf("gnt%0d", i),    32'(gnt[i]),    32'(g[i]));
      chk($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(rv[i]));
      chk($sformatf("rdata%0d", i),  rdata[i],       ed);
      chk($sformatf("outst%0d", i),  oc,
          rst ? 32'h0 : 32'(qa[i].size()));
      chk($sformatf("err%0d", i),    32'(err[i]),    32'(ee));
    end
    if (rvalid[2]) rv_cnt2++;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        qa[i].delete();
        qt[i].delete();
        pend[i]   = 1'b0;
        sticky[i] = 1'b0;
      end else begin
        if (rv[i]) begin
          void'(qa[i].pop_front());
          void'(qt[i].pop_front());
        end
        if (g[i]) begin
          qa[i].push_back(addr[i]);
          qt[i].push_back(cyc);
        end
        if (vi[i]) sticky[i] = 1'b1;
        pend[i]  = req[i] && !g[i];
        paddr[i] = addr[i];
      end
      lastg[i] = g[i];
    end
    cyc++;
    #1;
  endtask

  initial begin
    int k;
    n_vec = 0; n_err = 0; cyc = 0; rv_cnt2 = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; stall[i] = 1'b0; addr[i] = 32'h0;
      pend[i] = 1'b0; sticky[i] = 1'b0; lastg[i] = 1'b0;
      paddr[i] = 32'h0;
    end
    #1;
    // Request during reset must not be granted.
    req[0] = 1'b1; addr[0] = 32'h100;
    tick();
    tick();
    // Single request right after reset release.
    rst = 1'b0;
    tick();
    req[0] = 1'b0;
    tick();
    tick();

    // Three requests into a depth-2, latency-3 responder.
    k = 0;
    for (int j = 0; j < 10; j++) begin
      req[1]  = (k < 3);
      addr[1] = 32'(k * 4);
      tick();
      if (lastg[1]) k++;
    end
    req[1] = 1'b0;

    // Stall for 4 cycles, then release.
    req[0] = 1'b1; stall[0] = 1'b1; addr[0] = 32'h40;
    repeat (4) tick();
    stall[0] = 1'b0;
    tick();
    req[0] = 1'b0;
    repeat (2) tick();

    // Reset with two grants pending.
    req[1] = 1'b1; addr[1] = 32'h20;
    tick();
    addr[1] = 32'h24;
    tick();
    req[1] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // Address change on a stalled request.
    req[0] = 1'b1; stall[0] = 1'b1; addr[0] = 32'h10;
    tick();
    addr[0] = 32'h14;
    repeat (3) tick();
    req[0] = 1'b0; stall[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Back-to-back on the depth-1 instance.
    rv_cnt2 = 0;
    for (int j = 0; j < 10; j++) begin
      req[2]  = 1'b1;
      addr[2] = 32'h1000 + 32'(j * 4);
      tick();
    end
    req[2] = 1'b0;
    repeat (3) tick();
    chk("resp_cnt2", 32'(rv_cnt2), 32'd10);

    // Randomized traffic, mostly protocol-compliant, with reset pulses.
    for (int j = 0; j < 400; j++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 59) == 0) rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (!(req[i] && !lastg[i] && $urandom_range(0, 19) != 0)) begin
          req[i]  = ($urandom_range(0, 3) != 0);
          addr[i] = $urandom;
        end
        stall[i] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
